// File: rtl/if_stage_if.sv
// Instruction-memory request/acknowledge bundle between the fetch stage and imem.
// master: drives imem_req/imem_addr; slave: returns imem_ack/imem_rdata.
interface if_stage_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata
    );
endinterface

// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, fetches via imem handshake, presents to IF/ID.
// Ports: clk, rst (sync, active-high), PCWrite, redirect_valid/pc, imem (master),
//        InstOut, PCPlusOut, inst_valid, flush_out.
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              PCWrite,
    input  logic              redirect_valid,
    input  logic [31:0]       redirect_pc,
    if_stage_if.master        imem,
    output logic [31:0]       InstOut,
    output logic [31:0]       PCPlusOut,
    output logic              inst_valid,
    output logic              flush_out
);
    typedef enum logic [1:0] {IDLE, FETCH, READY, DRAIN} state_t;

    state_t      state, state_n;
    logic [31:0] pc, pc_n;
    logic [31:0] req_addr, req_n;
    logic [31:0] inst_buf, buf_n;
    logic [31:0] target;
    logic [31:0] pc_inc;

    assign target = {redirect_pc[31:2], 2'b00};
    assign pc_inc = pc + 32'd4;

    assign imem.imem_req  = (state == FETCH) || (state == DRAIN);
    assign imem.imem_addr = req_addr;
    assign inst_valid     = (state == READY);
    assign InstOut        = inst_valid ? inst_buf : NOP_INST;
    assign PCPlusOut      = pc_inc;
    assign flush_out      = redirect_valid && !rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            pc       <= RESET_PC;
            req_addr <= RESET_PC;
            inst_buf <= NOP_INST;
        end else begin
            state    <= state_n;
            pc       <= pc_n;
            req_addr <= req_n;
            inst_buf <= buf_n;
        end
    end

    always_comb begin
        state_n = state;
        pc_n    = pc;
        req_n   = req_addr;
        buf_n   = inst_buf;
        unique case (state)
            IDLE: begin
                state_n = FETCH;
                if (redirect_valid) begin
                    pc_n  = target;
                    req_n = target;
                end
            end
            FETCH: begin
                if (redirect_valid) begin
                    pc_n = target;
                    if (imem.imem_ack) begin
                        req_n = target;
                    end else begin
                        // Wrong-path request cannot be withdrawn; wait it out.
                        state_n = DRAIN;
                    end
                end else if (imem.imem_ack) begin
                    buf_n   = imem.imem_rdata;
                    state_n = READY;
                end
            end
            READY: begin
                if (redirect_valid) begin
                    pc_n    = target;
                    req_n   = target;
                    buf_n   = NOP_INST;
                    state_n = FETCH;
                end else if (PCWrite) begin
                    pc_n    = pc_inc;
                    req_n   = pc_inc;
                    state_n = FETCH;
                end
            end
            DRAIN: begin
                if (redirect_valid) begin
                    pc_n = target;
                end
                if (imem.imem_ack) begin
                    req_n   = redirect_valid ? target : pc;
                    state_n = FETCH;
                end
            end
            default: state_n = IDLE;
        endcase
    end
endmodule
